// File: rtl/xc_vtx_pkg.sv
// Shared state encoding, default sizes and memory transaction record for the
// xc_vtx instruction-retirement tracer.
package xc_vtx_pkg;

  localparam int NUM_TXN_DEF = 4;
  localparam int NUM_CPR_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    POST = 2'd2
  } vtx_state_t;

  typedef struct packed {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  ben;
    logic        error;
  } vtx_mem_txn_t;

endpackage

// File: rtl/xc_vtx_mem_recorder.sv
// Per-instruction memory transaction recorder: fills slots in grant order,
// saturates after NUM_TXN and raises a sticky overflow flag beyond that.
module xc_vtx_mem_recorder
  import xc_vtx_pkg::*;
#(
  parameter int NUM_TXN = NUM_TXN_DEF
) (
  input  logic                       g_clk,
  input  logic                       g_resetn,
  input  logic                       clear,
  input  logic                       enable,
  input  logic                       mem_cen,
  input  logic                       mem_gnt,
  input  logic                       mem_wen,
  input  logic [31:0]                mem_addr,
  input  logic [31:0]                mem_wdata,
  input  logic [31:0]                mem_rdata,
  input  logic [3:0]                 mem_ben,
  input  logic                       mem_error,
  output logic [NUM_TXN-1:0]         slot_valid,
  output vtx_mem_txn_t [NUM_TXN-1:0] slots,
  output logic                       ovf
);

  localparam int CW = $clog2(NUM_TXN + 1);

  logic [CW-1:0]              count_r;
  logic [NUM_TXN-1:0]         slot_valid_r;
  vtx_mem_txn_t [NUM_TXN-1:0] slots_r;
  logic                       ovf_r;
  logic                       fire_s;
  vtx_mem_txn_t               txn_s;

  assign fire_s = enable & mem_cen & mem_gnt;
  assign txn_s  = '{wen: mem_wen, addr: mem_addr, wdata: mem_wdata,
                    rdata: mem_rdata, ben: mem_ben, error: mem_error};

  // Slot fill with a saturating counter; overflow survives clear, only reset drops it
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      count_r      <= '0;
      slot_valid_r <= '0;
      slots_r      <= '0;
      ovf_r        <= 1'b0;
    end else if (clear) begin
      count_r      <= '0;
      slot_valid_r <= '0;
      slots_r      <= '0;
    end else if (fire_s) begin
      if (count_r < CW'(NUM_TXN)) begin
        for (int k = 0; k < NUM_TXN; k++) begin
          if (count_r == CW'(k)) begin
            slots_r[k]      <= txn_s;
            slot_valid_r[k] <= 1'b1;
          end
        end
        count_r <= count_r + CW'(1);
      end else begin
        ovf_r <= 1'b1;
      end
    end
  end

  assign slot_valid = slot_valid_r;
  assign slots      = slots_r;
  assign ovf        = ovf_r;

endmodule

// File: rtl/xc_vtx_tracer.sv
// Passive CPU<->COP instruction-retirement tracer producing one vtx record per
// instruction. Memory slot capture is compiled only with XC_VTX_MEM_TRACE_EN.
module xc_vtx_tracer
  import xc_vtx_pkg::*;
#(
  parameter int NUM_TXN = NUM_TXN_DEF,
  parameter int NUM_CPR = NUM_CPR_DEF
) (
  input  logic                   g_clk,
  input  logic                   g_resetn,
  input  logic                   cpu_insn_req,
  input  logic                   cop_insn_ack,
  input  logic [31:0]            cpu_insn_enc,
  input  logic [31:0]            cpu_rs1,
  input  logic                   cop_insn_rsp,
  input  logic                   cpu_insn_ack,
  input  logic [2:0]             cop_result,
  input  logic                   cop_wen,
  input  logic [4:0]             cop_waddr,
  input  logic [31:0]            cop_wdata,
  input  logic [32*NUM_CPR-1:0]  cprs,
  input  logic                   mem_cen,
  input  logic                   mem_gnt,
  input  logic                   mem_wen,
  input  logic [31:0]            mem_addr,
  input  logic [31:0]            mem_wdata,
  input  logic [31:0]            mem_rdata,
  input  logic [3:0]             mem_ben,
  input  logic                   mem_error,
  output logic                   vtx_valid,
  output logic [31:0]            vtx_instr_enc,
  output logic [31:0]            vtx_instr_rs1,
  output logic [2:0]             vtx_instr_result,
  output logic                   vtx_instr_wen,
  output logic [4:0]             vtx_instr_waddr,
  output logic [31:0]            vtx_instr_wdata,
  output logic [32*NUM_CPR-1:0]  vtx_cprs_pre,
  output logic [32*NUM_CPR-1:0]  vtx_cprs_post,
  output logic [NUM_TXN-1:0]     vtx_mem_cen,
  output logic [NUM_TXN-1:0]     vtx_mem_wen,
  output logic [32*NUM_TXN-1:0]  vtx_mem_addr,
  output logic [32*NUM_TXN-1:0]  vtx_mem_wdata,
  output logic [32*NUM_TXN-1:0]  vtx_mem_rdata,
  output logic [4*NUM_TXN-1:0]   vtx_mem_ben,
  output logic [NUM_TXN-1:0]     vtx_mem_error,
  output logic                   vtx_mem_ovf,
  output logic                   vtx_proto_err
);

  vtx_state_t            state_r, state_nxt_s;
  logic                  req_hs_s, rsp_hs_s;
  logic                  start_s, finish_s, stray_s;
  logic                  valid_r, proto_err_r;
  logic [31:0]           enc_r, rs1_r, wdata_r;
  logic [2:0]            result_r;
  logic                  wen_r;
  logic [4:0]            waddr_r;
  logic [32*NUM_CPR-1:0] pre_r, post_r;

  assign req_hs_s = cpu_insn_req & cop_insn_ack;
  assign rsp_hs_s = cop_insn_rsp & cpu_insn_ack;

  // State register
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state plus capture strobes; a request overlapping a response in BUSY is dropped
  always_comb begin
    state_nxt_s = state_r;
    start_s     = 1'b0;
    finish_s    = 1'b0;
    stray_s     = 1'b0;
    case (state_r)
      IDLE: begin
        stray_s = rsp_hs_s;
        if (req_hs_s) begin
          state_nxt_s = BUSY;
          start_s     = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        if (rsp_hs_s) begin
          state_nxt_s = POST;
          finish_s    = 1'b1;
          stray_s     = req_hs_s;
        end else begin
          state_nxt_s = BUSY;
        end
      end
      POST: begin
        if (req_hs_s) begin
          state_nxt_s = BUSY;
          start_s     = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Record field capture at the request, response and post-snapshot edges
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      valid_r     <= 1'b0;
      proto_err_r <= 1'b0;
      enc_r       <= '0;
      rs1_r       <= '0;
      pre_r       <= '0;
      post_r      <= '0;
      result_r    <= '0;
      wen_r       <= 1'b0;
      waddr_r     <= '0;
      wdata_r     <= '0;
    end else begin
      valid_r <= finish_s;
      if (start_s) begin
        enc_r <= cpu_insn_enc;
        rs1_r <= cpu_rs1;
        pre_r <= cprs;
      end
      if (finish_s) begin
        result_r <= cop_result;
        wen_r    <= cop_wen;
        waddr_r  <= cop_waddr;
        wdata_r  <= cop_wdata;
      end
      if (state_r == POST) begin
        post_r <= cprs;
      end
      if (stray_s) begin
        proto_err_r <= 1'b1;
      end
    end
  end

  assign vtx_valid        = valid_r;
  assign vtx_instr_enc    = enc_r;
  assign vtx_instr_rs1    = rs1_r;
  assign vtx_instr_result = result_r;
  assign vtx_instr_wen    = wen_r;
  assign vtx_instr_waddr  = waddr_r;
  assign vtx_instr_wdata  = wdata_r;
  assign vtx_cprs_pre     = pre_r;
  assign vtx_proto_err    = proto_err_r;
  // COP writeback lands at the response edge, so the post view is live cprs while valid is high
  assign vtx_cprs_post    = (state_r == POST) ? cprs : post_r;

`ifdef XC_VTX_MEM_TRACE_EN
  logic                       mem_en_s;
  logic [NUM_TXN-1:0]         slot_valid_s;
  vtx_mem_txn_t [NUM_TXN-1:0] slots_s;
  logic                       ovf_s;

  assign mem_en_s = (state_r == BUSY);

  xc_vtx_mem_recorder #(
    .NUM_TXN (NUM_TXN)
  ) u_mem_recorder (
    .g_clk      (g_clk),
    .g_resetn   (g_resetn),
    .clear      (start_s),
    .enable     (mem_en_s),
    .mem_cen    (mem_cen),
    .mem_gnt    (mem_gnt),
    .mem_wen    (mem_wen),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ben    (mem_ben),
    .mem_error  (mem_error),
    .slot_valid (slot_valid_s),
    .slots      (slots_s),
    .ovf        (ovf_s)
  );

  for (genvar k = 0; k < NUM_TXN; k++) begin : g_slot
    assign vtx_mem_wen[k]           = slots_s[k].wen;
    assign vtx_mem_error[k]         = slots_s[k].error;
    assign vtx_mem_addr[32*k +: 32] = slots_s[k].addr;
    assign vtx_mem_wdata[32*k +: 32] = slots_s[k].wdata;
    assign vtx_mem_rdata[32*k +: 32] = slots_s[k].rdata;
    assign vtx_mem_ben[4*k +: 4]    = slots_s[k].ben;
  end

  assign vtx_mem_cen = slot_valid_s;
  assign vtx_mem_ovf = ovf_s;
`else
  logic mem_unused_s;

  assign mem_unused_s  = ^{mem_cen, mem_gnt, mem_wen, mem_addr, mem_wdata,
                           mem_rdata, mem_ben, mem_error};
  assign vtx_mem_cen   = '0;
  assign vtx_mem_wen   = '0;
  assign vtx_mem_error = '0;
  assign vtx_mem_addr  = '0;
  assign vtx_mem_wdata = '0;
  assign vtx_mem_rdata = '0;
  assign vtx_mem_ben   = '0;
  assign vtx_mem_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_xc_vtx_tracer.sv
// Self-checking bench for xc_vtx_tracer: directed protocol scenarios plus
// randomized instructions scored against a transaction-level record model.
module tb_xc_vtx_tracer;

  logic         g_clk = 1'b0;
  logic         g_resetn = 1'b0;
  logic         cpu_insn_req, cop_insn_ack, cop_insn_rsp, cpu_insn_ack;
  logic [31:0]  cpu_insn_enc, cpu_rs1, cop_wdata;
  logic [2:0]   cop_result;
  logic         cop_wen;
  logic [4:0]   cop_waddr;
  logic [511:0] cprs;
  logic         mem_cen, mem_gnt, mem_wen, mem_error;
  logic [31:0]  mem_addr, mem_wdata, mem_rdata;
  logic [3:0]   mem_ben;

  logic         vtx_valid, vtx_instr_wen, vtx_mem_ovf, vtx_proto_err;
  logic [31:0]  vtx_instr_enc, vtx_instr_rs1, vtx_instr_wdata;
  logic [2:0]   vtx_instr_result;
  logic [4:0]   vtx_instr_waddr;
  logic [511:0] vtx_cprs_pre, vtx_cprs_post;
  logic [3:0]   vtx_mem_cen, vtx_mem_wen, vtx_mem_error;
  logic [127:0] vtx_mem_addr, vtx_mem_wdata, vtx_mem_rdata;
  logic [15:0]  vtx_mem_ben;

  xc_vtx_tracer dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .cpu_insn_req(cpu_insn_req), .cop_insn_ack(cop_insn_ack),
    .cpu_insn_enc(cpu_insn_enc), .cpu_rs1(cpu_rs1),
    .cop_insn_rsp(cop_insn_rsp), .cpu_insn_ack(cpu_insn_ack),
    .cop_result(cop_result), .cop_wen(cop_wen), .cop_waddr(cop_waddr),
    .cop_wdata(cop_wdata), .cprs(cprs),
    .mem_cen(mem_cen), .mem_gnt(mem_gnt), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ben(mem_ben), .mem_error(mem_error),
    .vtx_valid(vtx_valid), .vtx_instr_enc(vtx_instr_enc),
    .vtx_instr_rs1(vtx_instr_rs1), .vtx_instr_result(vtx_instr_result),
    .vtx_instr_wen(vtx_instr_wen), .vtx_instr_waddr(vtx_instr_waddr),
    .vtx_instr_wdata(vtx_instr_wdata),
    .vtx_cprs_pre(vtx_cprs_pre), .vtx_cprs_post(vtx_cprs_post),
    .vtx_mem_cen(vtx_mem_cen), .vtx_mem_wen(vtx_mem_wen),
    .vtx_mem_addr(vtx_mem_addr), .vtx_mem_wdata(vtx_mem_wdata),
    .vtx_mem_rdata(vtx_mem_rdata), .vtx_mem_ben(vtx_mem_ben),
    .vtx_mem_error(vtx_mem_error), .vtx_mem_ovf(vtx_mem_ovf),
    .vtx_proto_err(vtx_proto_err)
  );

  always #5 g_clk = ~g_clk;

  typedef struct packed {
    logic        wen;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  ben;
    logic        err;
  } txn_t;

  // Reference record: what the checker should see for the latest instruction
  logic [31:0]  m_enc, m_rs1, m_wdata;
  logic [2:0]   m_result;
  logic         m_wen, m_ovf, m_proto;
  logic [4:0]   m_waddr;
  logic [511:0] m_pre, m_post, first_post, tmp_cprs;
  txn_t         txn_q[$];
  int           checks = 0;
  int           errors = 0;
  bit           in_post;

  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  task automatic quiet();
    cpu_insn_req = 1'b0; cop_insn_ack = 1'b0;
    cop_insn_rsp = 1'b0; cpu_insn_ack = 1'b0;
    mem_cen = 1'b0; mem_gnt = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_enc = '0; m_rs1 = '0; m_wdata = '0; m_result = '0; m_wen = 1'b0;
    m_waddr = '0; m_pre = '0; m_post = '0; m_ovf = 1'b0; m_proto = 1'b0;
    txn_q.delete();
  endtask

  task automatic check_record(input string tag, input logic exp_valid);
    logic [3:0]   c, w, e;
    logic [127:0] a, wd, rd;
    logic [15:0]  b;
    logic         ovf;
    c = '0; w = '0; e = '0; a = '0; wd = '0; rd = '0; b = '0; ovf = 1'b0;
`ifdef XC_VTX_MEM_TRACE_EN
    for (int k = 0; k < 4; k++) begin
      if (k < txn_q.size()) begin
        c[k] = 1'b1; w[k] = txn_q[k].wen; e[k] = txn_q[k].err;
        a[32*k +: 32] = txn_q[k].addr; wd[32*k +: 32] = txn_q[k].wdata;
        rd[32*k +: 32] = txn_q[k].rdata; b[4*k +: 4] = txn_q[k].ben;
      end
    end
    ovf = m_ovf;
`endif
    chk({tag, ".valid"}, vtx_valid, exp_valid);
    chk({tag, ".enc"}, vtx_instr_enc, m_enc);
    chk({tag, ".rs1"}, vtx_instr_rs1, m_rs1);
    chk({tag, ".result"}, vtx_instr_result, m_result);
    chk({tag, ".wen"}, vtx_instr_wen, m_wen);
    chk({tag, ".waddr"}, vtx_instr_waddr, m_waddr);
    chk({tag, ".wdata"}, vtx_instr_wdata, m_wdata);
    chk({tag, ".pre"}, vtx_cprs_pre, m_pre);
    chk({tag, ".post"}, vtx_cprs_post, m_post);
    chk({tag, ".mem_cen"}, vtx_mem_cen, c);
    chk({tag, ".mem_wen"}, vtx_mem_wen, w);
    chk({tag, ".mem_err"}, vtx_mem_error, e);
    chk({tag, ".mem_addr"}, vtx_mem_addr, a);
    chk({tag, ".mem_wdata"}, vtx_mem_wdata, wd);
    chk({tag, ".mem_rdata"}, vtx_mem_rdata, rd);
    chk({tag, ".mem_ben"}, vtx_mem_ben, b);
    chk({tag, ".ovf"}, vtx_mem_ovf, ovf);
    chk({tag, ".proto"}, vtx_proto_err, m_proto);
  endtask

  task automatic noise();
    mem_cen = 1'b1; mem_gnt = 1'b1; mem_wen = 1'($urandom);
    mem_addr = $urandom; mem_wdata = $urandom; mem_rdata = $urandom;
    mem_ben = 4'($urandom); mem_error = 1'($urandom);
  endtask

  task automatic poke_cprs();
    int r;
    r = $urandom_range(0, 15);
    cprs[32*r +: 32] = $urandom;
  endtask

  // Request handshake; caller may already have driven ignored bus noise
  task automatic issue(input logic [31:0] enc, input logic [31:0] rs1);
    cpu_insn_req = 1'b1; cop_insn_ack = 1'b1;
    cpu_insn_enc = enc; cpu_rs1 = rs1;
    m_enc = enc; m_rs1 = rs1; m_pre = cprs;
    txn_q.delete();
    tick();
    quiet();
    chk("issue.valid_low", vtx_valid, 1'b0);
  endtask

  task automatic mem_txn(input logic gnt, input logic wen, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rd,
                         input logic [3:0] ben, input logic err);
    mem_cen = 1'b1; mem_gnt = gnt; mem_wen = wen; mem_addr = addr;
    mem_wdata = wd; mem_rdata = rd; mem_ben = ben; mem_error = err;
    if (gnt) begin
      txn_q.push_back('{wen: wen, addr: addr, wdata: wd, rdata: rd, ben: ben, err: err});
      if (txn_q.size() > 4) m_ovf = 1'b1;
    end
    tick();
    quiet();
  endtask

  // Response handshake, then the POST cycle where the COP writeback is visible
  task automatic respond(input string tag, input logic [2:0] res, input logic wen,
                         input logic [4:0] waddr, input logic [31:0] wdata,
                         input logic with_req, input logic [511:0] new_cprs);
    cop_insn_rsp = 1'b1; cpu_insn_ack = 1'b1;
    cop_result = res; cop_wen = wen; cop_waddr = waddr; cop_wdata = wdata;
    m_result = res; m_wen = wen; m_waddr = waddr; m_wdata = wdata;
    if (with_req) begin
      cpu_insn_req = 1'b1; cop_insn_ack = 1'b1;
      cpu_insn_enc = $urandom; cpu_rs1 = $urandom;
      m_proto = 1'b1;
    end
    tick();
    quiet();
    cprs = new_cprs;
    m_post = new_cprs;
    #1;
    check_record(tag, 1'b1);
  endtask

  task automatic hard_reset(input string tag);
    g_resetn = 1'b0;
    #1;
    model_reset();
    check_record(tag, 1'b0);
    tick();
    g_resetn = 1'b1;
  endtask

  initial begin
    quiet();
    cpu_insn_enc = '0; cpu_rs1 = '0; cop_result = '0; cop_wen = 1'b0;
    cop_waddr = '0; cop_wdata = '0; cprs = '0;
    mem_wen = 1'b0; mem_addr = '0; mem_wdata = '0; mem_rdata = '0;
    mem_ben = '0; mem_error = 1'b0;
    model_reset();
    tick();
    hard_reset("reset");

    // Single instruction: cprs[3] goes 0 -> 5
    issue(32'h0000_102B, 32'h0000_1234);
    tick();
    tmp_cprs = cprs;
    tmp_cprs[127:96] = 32'd5;
    respond("single", 3'd1, 1'b1, 5'd7, 32'hCAFE_0001, 1'b0, tmp_cprs);
    chk("single.pre3", vtx_cprs_pre[127:96], 32'd0);
    chk("single.post3", vtx_cprs_post[127:96], 32'd5);
    tick();
    check_record("single_hold", 1'b0);

    // Two loads
    issue(32'h0000_2003, 32'h0000_0100);
    mem_txn(1'b1, 1'b0, 32'h100, 32'h0, 32'hAA, 4'hF, 1'b0);
    mem_txn(1'b1, 1'b0, 32'h104, 32'h0, 32'hBB, 4'hF, 1'b0);
    respond("loads", 3'd0, 1'b0, 5'd0, 32'd0, 1'b0, cprs);
`ifdef XC_VTX_MEM_TRACE_EN
    chk("loads.cen", vtx_mem_cen, 4'b0011);
    chk("loads.rdata1", vtx_mem_rdata[63:32], 32'hBB);
`else
    chk("loads.cen", vtx_mem_cen, 4'b0000);
`endif
    chk("loads.ovf", vtx_mem_ovf, 1'b0);
    tick();
    check_record("loads_hold", 1'b0);

    // Randomized instructions with optional back-to-back issue
    in_post = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (!in_post) begin
        repeat ($urandom_range(0, 2)) begin
          if ($urandom_range(0, 1) == 1) noise();
          poke_cprs();
          tick();
          quiet();
        end
      end else if ($urandom_range(0, 1) == 1) begin
        noise();
      end
      issue($urandom, $urandom);
      repeat ($urandom_range(0, 6)) begin
        case ($urandom_range(0, 3))
          0, 1: mem_txn(1'b1, 1'($urandom), $urandom, $urandom, $urandom, 4'($urandom), 1'($urandom));
          2: mem_txn(1'b0, 1'($urandom), $urandom, $urandom, $urandom, 4'($urandom), 1'($urandom));
          default: begin
            poke_cprs();
            tick();
          end
        endcase
      end
      tmp_cprs = cprs;
      tmp_cprs[32*$urandom_range(0, 15) +: 32] = $urandom;
      respond("rnd", 3'($urandom), 1'($urandom), 5'($urandom), $urandom, 1'b0, tmp_cprs);
      in_post = 1'b1;
      if ($urandom_range(0, 1) == 0 || i == 15) begin
        if ($urandom_range(0, 1) == 1) noise();
        tick();
        quiet();
        check_record("rnd_hold", 1'b0);
        in_post = 1'b0;
      end
    end

    // Overflow: five granted transactions
    hard_reset("reset2");
    issue(32'h0000_3003, 32'h0000_0200);
    for (int k = 0; k < 5; k++) begin
      mem_txn(1'b1, 1'b1, 32'h200 + 32'(4 * k), 32'h5500 + 32'(k), 32'h0, 4'h3, 1'b0);
    end
    respond("ovf", 3'd2, 1'b0, 5'd0, 32'd0, 1'b0, cprs);
`ifdef XC_VTX_MEM_TRACE_EN
    chk("ovf.cen", vtx_mem_cen, 4'b1111);
    chk("ovf.slot3_addr", vtx_mem_addr[127:96], 32'h20C);
    chk("ovf.flag", vtx_mem_ovf, 1'b1);
`else
    chk("ovf.flag", vtx_mem_ovf, 1'b0);
`endif
    tick();
    check_record("ovf_hold", 1'b0);

    // Request overlapping a response: response wins, request dropped, flagged
    issue(32'h0000_4003, 32'h0000_0004);
    mem_txn(1'b1, 1'b0, 32'h300, 32'h0, 32'h77, 4'h1, 1'b1);
    respond("overlap", 3'd3, 1'b1, 5'd9, 32'h1234_5678, 1'b1, cprs);
    tick();
    check_record("overlap_idle", 1'b0);
    tick();
    check_record("overlap_idle2", 1'b0);

    // Back-to-back: next request in the POST cycle
    hard_reset("reset3");
    issue(32'h0000_5003, 32'h0000_0011);
    tick();
    tmp_cprs = cprs;
    tmp_cprs[31:0] = 32'hDEAD_BEEF;
    respond("b2b_a", 3'd4, 1'b1, 5'd1, 32'h1, 1'b0, tmp_cprs);
    first_post = m_post;
    issue(32'h0000_6003, 32'h0000_0022);
    chk("b2b.pre_eq_post", vtx_cprs_pre, first_post);
    poke_cprs();
    tick();
    tmp_cprs = cprs;
    tmp_cprs[63:32] = 32'h0BAD_F00D;
    respond("b2b_b", 3'd5, 1'b0, 5'd2, 32'h2, 1'b0, tmp_cprs);
    tick();
    check_record("b2b_hold", 1'b0);

    // Stray response in IDLE
    cop_insn_rsp = 1'b1; cpu_insn_ack = 1'b1;
    tick();
    quiet();
    m_proto = 1'b1;
    check_record("stray", 1'b0);

    // Reset mid-instruction, then the orphaned response
    issue(32'h0000_7003, 32'h0000_0033);
    mem_txn(1'b1, 1'b1, 32'h400, 32'h99, 32'h0, 4'hF, 1'b0);
    hard_reset("rst_mid");
    cop_insn_rsp = 1'b1; cpu_insn_ack = 1'b1;
    tick();
    quiet();
    m_proto = 1'b1;
    check_record("rst_mid_rsp", 1'b0);
    tick();
    check_record("rst_mid_after", 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
